// File: rtl/audio_i2s_slave.sv
// Slave-side I2S port: resynchronises external BCLK/LRCK/SDIN into the fabric
// clock domain, deserialises left/right ADC words, serialises DAC words onto
// SDOUT, and tracks frame timing to qualify received words with LOCKED.
module audio_i2s_slave #(
  parameter int unsigned DATA_BITS = 24
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 BCLK,
  input  logic                 LRCK,
  input  logic                 SDIN,
  output logic                 SDOUT,
  input  logic [DATA_BITS-1:0] TX_LEFT,
  input  logic [DATA_BITS-1:0] TX_RIGHT,
  output logic                 TX_ACK,
  output logic [DATA_BITS-1:0] RX_LEFT,
  output logic [DATA_BITS-1:0] RX_RIGHT,
  output logic                 RX_VALID,
  output logic                 LOCKED,
  output logic                 FRAME_ERR
);

  localparam int unsigned CW = $clog2(2 * DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(2 * DATA_BITS);
  localparam logic [CW-1:0] CNT_GOOD = CW'(DATA_BITS - 1);

  // Lock tracking: ST_ARM is the post-reset state where the first change edge
  // only arms checking; ST_GOOD1 means one good change edge seen so far.
  typedef enum logic [1:0] {
    ST_ARM,
    ST_HUNT,
    ST_GOOD1,
    ST_LOCK
  } lock_state_t;

  lock_state_t state, state_nx;

  logic [1:0]           bclk_sync, lr_sync, d_sync;
  logic                 bclk_dly;
  logic                 rise, fall, lr, d, change, good;
  logic                 lr_prev;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] rx_sr, rx_word, left_hold;
  logic [DATA_BITS-1:0] tx_sr, tx_hold;
  logic                 word_ok, word_bad;

  // Two-flop synchronisers for the external pins plus a delayed BCLK copy for edge detection
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      d_sync    <= '0;
      bclk_dly  <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], BCLK};
      lr_sync   <= {lr_sync[0], LRCK};
      d_sync    <= {d_sync[0], SDIN};
      bclk_dly  <= bclk_sync[1];
    end
  end

  assign rise    = bclk_sync[1] & ~bclk_dly;
  assign fall    = ~bclk_sync[1] & bclk_dly;
  assign lr      = lr_sync[1];
  assign d       = d_sync[1];
  assign change  = rise & (lr != lr_prev);
  assign good    = (bit_cnt == CNT_GOOD);
  assign rx_word = {rx_sr[DATA_BITS-2:0], d};

  // Lock state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_ARM;
    else          state <= state_nx;
  end

  // Lock next-state: advance only on change edges
  always_comb begin
    state_nx = state;
    if (change) begin
      case (state)
        ST_ARM:   state_nx = ST_HUNT;
        ST_HUNT:  state_nx = good ? ST_GOOD1 : ST_HUNT;
        ST_GOOD1: state_nx = good ? ST_LOCK  : ST_HUNT;
        ST_LOCK:  state_nx = good ? ST_LOCK  : ST_HUNT;
        default:  state_nx = ST_HUNT;
      endcase
    end
  end

  // Lock outputs and change-edge qualification
  always_comb begin
    LOCKED   = (state == ST_LOCK);
    word_ok  = 1'b0;
    word_bad = 1'b0;
    if (change && state != ST_ARM) begin
      word_ok  = good;
      word_bad = !good;
    end
  end

  // Receive shifter, slot bit counter and channel tracking on each BCLK rise
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_sr   <= '0;
      bit_cnt <= '0;
      lr_prev <= 1'b0;
    end else if (rise) begin
      rx_sr   <= rx_word;
      lr_prev <= lr;
      if (change)                bit_cnt <= '0;
      else if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Received word capture and presentation; the completed word belongs to lr_prev
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      left_hold <= '0;
      RX_LEFT   <= '0;
      RX_RIGHT  <= '0;
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      RX_VALID  <= 1'b0;
      FRAME_ERR <= word_bad;
      if (word_ok && !lr_prev) left_hold <= rx_word;
      if (word_ok && lr_prev && LOCKED) begin
        RX_LEFT  <= left_hold;
        RX_RIGHT <= rx_word;
        RX_VALID <= 1'b1;
      end
    end
  end

  // Transmit: load words on change edges, shift MSB-first out on each BCLK fall
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_sr   <= '0;
      tx_hold <= '0;
      SDOUT   <= 1'b0;
      TX_ACK  <= 1'b0;
    end else begin
      TX_ACK <= 1'b0;
      if (change && !lr) begin
        tx_hold <= TX_RIGHT;
        tx_sr   <= TX_LEFT;
        TX_ACK  <= 1'b1;
      end else if (change) begin
        tx_sr <= tx_hold;
      end else if (fall) begin
        SDOUT <= tx_sr[DATA_BITS-1];
        tx_sr <= {tx_sr[DATA_BITS-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_slave.sv
// Directed bench for audio_i2s_slave: drives I2S frames from a bit-level
// generator and checks RX words, SDOUT content, lock and error behaviour.
`timescale 1ns/1ps
module tb_audio_i2s_slave;
  localparam int unsigned DATA_BITS = 24;
  localparam time HALF = 60ns;

  logic clk = 1'b0, rst_n = 1'b0, bclk = 1'b0, lrck = 1'b0;
  logic sdin_drv = 1'b0, loop = 1'b0;
  logic sdin, sdout, tx_ack, rx_valid, locked, frame_err;
  logic [DATA_BITS-1:0] tx_left, tx_right, rx_left, rx_right;

  assign sdin = loop ? sdout : sdin_drv;

  audio_i2s_slave #(.DATA_BITS(DATA_BITS)) dut (
    .CLK(clk), .RESET_N(rst_n), .BCLK(bclk), .LRCK(lrck), .SDIN(sdin),
    .SDOUT(sdout), .TX_LEFT(tx_left), .TX_RIGHT(tx_right), .TX_ACK(tx_ack),
    .RX_LEFT(rx_left), .RX_RIGHT(rx_right), .RX_VALID(rx_valid),
    .LOCKED(locked), .FRAME_ERR(frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int rxv_cnt = 0, fe_cnt = 0, ack_cnt = 0;
  logic [DATA_BITS-1:0] tx_shift = '0, tx_prev_word = '0;
  logic prev_lsb = 1'b0;

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (rx_valid)  rxv_cnt++;
    if (frame_err) fe_cnt++;
    if (tx_ack)    ack_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One BCLK period: data/LRCK change after the fall, SDOUT sampled just before the rise
  task automatic send_bit(input logic lr, input logic b);
    lrck = lr;
    sdin_drv = b;
    #(HALF);
    tx_shift = {tx_shift[DATA_BITS-2:0], sdout};
    bclk = 1'b1;
    #(HALF);
    bclk = 1'b0;
  endtask

  // Slot of n BCLKs: period 0 carries the previous word's LSB, then w MSB-first
  task automatic send_slot(input logic lr, input logic [DATA_BITS-1:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        send_bit(lr, prev_lsb);
        tx_prev_word = tx_shift;
      end else begin
        send_bit(lr, w[DATA_BITS-k]);
      end
    end
    if (n >= 1 && n <= DATA_BITS) prev_lsb = w[DATA_BITS-n];
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] l, input logic [DATA_BITS-1:0] r);
    send_slot(1'b0, l, DATA_BITS);
    send_slot(1'b1, r, DATA_BITS);
  endtask

  initial begin
    int n_rx, n_fe, n_ack, changes;
    logic s;
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rx, n_fe, n_ack, changes;
    logic s;
    tx_left  = 24'h800001;
    tx_right = 24'h7FFFFE;
    @(negedge clk);

    // Reset held with BCLK toggling
    for (int i = 0; i < 8; i++) send_bit(1'b1, i[0]);
    check("rst_sdout", sdout, 0);
    check("rst_rx_left", rx_left, 0);
    check("rst_rx_right", rx_right, 0);
    check("rst_locked", locked, 0);
    check("rst_rxv_cnt", rxv_cnt, 0);
    check("rst_ack_cnt", ack_cnt, 0);
    check("rst_fe_cnt", fe_cnt, 0);
    lrck = 1'b0;
    #(HALF);
    rst_n = 1'b1;
    #(HALF);

    // Receive and transmit with external frames
    send_frame(24'hABCDEF, 24'h123456);
    check("arm_no_ferr", fe_cnt, 0);
    check("arm_unlocked", locked, 0);
    send_slot(1'b0, 24'hABCDEF, DATA_BITS);
    check("good1_unlocked", locked, 0);
    check("ack_first", ack_cnt, 1);
    send_slot(1'b1, 24'h123456, DATA_BITS);
    check("locked_rise", locked, 1);
    check("tx_left_word", tx_prev_word, 24'h800001);
    send_slot(1'b0, 24'hABCDEF, DATA_BITS);
    check("rxv_first", rxv_cnt, 1);
    check("rx_left", rx_left, 24'hABCDEF);
    check("rx_right", rx_right, 24'h123456);
    check("tx_right_word", tx_prev_word, 24'h7FFFFE);
    check("ack_second", ack_cnt, 2);
    send_slot(1'b1, 24'h123456, DATA_BITS);
    check("tx_left_word2", tx_prev_word, 24'h800001);
    send_slot(1'b0, 24'hABCDEF, DATA_BITS);
    check("rxv_second", rxv_cnt, 2);
    check("tx_right_word2", tx_prev_word, 24'h7FFFFE);
    check("ack_third", ack_cnt, 3);
    send_slot(1'b1, 24'h123456, DATA_BITS);

    // Loopback SDOUT -> SDIN
    tx_left  = 24'h5A5A5A;
    tx_right = 24'hC3C3C3;
    loop = 1'b1;
    send_frame(24'h5A5A5A, 24'hC3C3C3);
    check("loop_tx_left", tx_prev_word, 24'h5A5A5A);
    send_slot(1'b0, 24'h5A5A5A, DATA_BITS);
    check("loop_rxv", rxv_cnt, 4);
    check("loop_rx_left", rx_left, 24'h5A5A5A);
    check("loop_rx_right", rx_right, 24'hC3C3C3);
    check("loop_tx_right", tx_prev_word, 24'hC3C3C3);
    send_slot(1'b1, 24'hC3C3C3, DATA_BITS);
    loop = 1'b0;
    tx_left  = 24'h800001;
    tx_right = 24'h7FFFFE;

    // Short left slot
    n_rx = rxv_cnt;
    send_slot(1'b0, 24'hAAAAAA, DATA_BITS - 1);
    check("short_prev_rxv", rxv_cnt, n_rx + 1);
    send_slot(1'b1, 24'h555555, DATA_BITS);
    check("short_ferr", fe_cnt, 1);
    check("short_unlock", locked, 0);
    send_slot(1'b0, 24'h0F1E2D, DATA_BITS);
    check("short_relock_wait", locked, 0);
    check("short_no_rxv", rxv_cnt, n_rx + 1);
    send_slot(1'b1, 24'hF0E1D2, DATA_BITS);
    check("short_relock", locked, 1);
    check("short_ferr_once", fe_cnt, 1);
    send_slot(1'b0, 24'h0F1E2D, DATA_BITS);
    check("short_rxv_resume", rxv_cnt, n_rx + 2);
    check("short_rx_left", rx_left, 24'h0F1E2D);
    check("short_rx_right", rx_right, 24'hF0E1D2);

    // Reset during bit 10 of a right slot
    send_slot(1'b1, 24'hF0E1D2, 10);
    check("pre_rst_sdout", sdout, 1);
    lrck = 1'b1;
    #20ns;
    rst_n = 1'b0;
    #1ns;
    check("mid_rst_sdout", sdout, 0);
    check("mid_rst_rx_left", rx_left, 0);
    check("mid_rst_rx_right", rx_right, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_pulses", {rx_valid, tx_ack, frame_err}, 0);
    #9ns;
    repeat (20) @(negedge clk);
    lrck = 1'b0;
    #(HALF);
    rst_n = 1'b1;
    #(HALF);
    n_rx = rxv_cnt; n_fe = fe_cnt; n_ack = ack_cnt;
    send_frame(24'h13579B, 24'h2468AC);
    send_frame(24'h13579B, 24'h2468AC);
    check("post_rst_locked", locked, 1);
    check("post_rst_ack", ack_cnt, n_ack + 1);
    check("post_rst_tx_left", tx_prev_word, 24'h800001);
    send_slot(1'b0, 24'h13579B, DATA_BITS);
    check("post_rst_rxv", rxv_cnt, n_rx + 1);
    check("post_rst_rx_left", rx_left, 24'h13579B);
    check("post_rst_rx_right", rx_right, 24'h2468AC);
    check("post_rst_no_ferr", fe_cnt, n_fe);

    // BCLK stopped mid right slot, then restarted out of position
    send_slot(1'b1, 24'h2468AC, 12);
    n_rx = rxv_cnt; n_fe = fe_cnt;
    s = sdout;
    changes = 0;
    repeat (1000) begin
      @(negedge clk);
      if (sdout !== s) changes++;
    end
    check("stop_sdout_const", changes, 0);
    check("stop_no_rxv", rxv_cnt, n_rx);
    check("stop_no_ferr", fe_cnt, n_fe);
    check("stop_lock_held", locked, 1);
    send_slot(1'b1, 24'h2468AC, 5);
    send_slot(1'b0, 24'h13579B, DATA_BITS);
    check("restart_ferr", fe_cnt, n_fe + 1);
    check("restart_unlock", locked, 0);
    check("restart_no_rxv", rxv_cnt, n_rx);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
